// File: rtl/riscv_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit.
//   XLEN_DEF       default operand/result width
//   muldiv_op_e    funct3 encoding of the M-extension operations
//   muldiv_state_e sequencing states of the multiply/divide unit
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit.
//   flush_i, start_i, op_i, a_i, b_i, rd_i   : request from ID/EX (into the unit)
//   stall_o, busy_o                          : pipeline hold / activity
//   result_valid_o, result_o, rd_o           : completed result towards EX/MEM
// Modports: slave = the unit, master = the pipeline driving it.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
) ();

    logic            flush_i;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic            stall_o;
    logic            busy_o;
    logic            result_valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport slave (
        input  flush_i, start_i, op_i, a_i, b_i, rd_i,
        output stall_o, busy_o, result_valid_o, result_o, rd_o
    );

    modport master (
        output flush_i, start_i, op_i, a_i, b_i, rd_i,
        input  stall_o, busy_o, result_valid_o, result_o, rd_o
    );

endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture dividend/divisor and clear the partial remainder
//   step                perform one restoring iteration
//   dividend, divisor   unsigned magnitudes
//   quotient, remainder unsigned results, valid after XLEN steps
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic            fits;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while the new quotient bit enters at the LSB.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            // When it fits, shifted - divisor < divisor, so XLEN-bit math is exact.
            rem_q <= fits ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in the EX stage.
// Accepts one M-op from IDLE, stalls the pipeline while iterating, then
// presents result_o/rd_o with a one-cycle result_valid_o pulse in DONE.
//   clk, rst_n : clock, asynchronous active-low reset
//   mdu        : ex_muldiv_unit_if.slave (request, stall/busy, result)
// Build option: MULDIV_FAST_MUL_EN -- MUL* ops resolve in one cycle with a
// single (XLEN+1)x(XLEN+1) signed multiply; division stays iterative.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_unit_if.slave mdu
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    muldiv_state_e   state, state_nx;
    logic [CNT_W-1:0] count;
    muldiv_op_e      op_q;
    logic [4:0]      rd_q, rd_hold_q;
    logic            q_neg_q, r_neg_q, special_q;
    logic [XLEN-1:0] special_res_q, res_hold_q;
    logic [2*XLEN-1:0] prod_q, mcand_q;
    logic [XLEN-1:0] mplier_q;

    muldiv_op_e      op_in;
    logic            accept, is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic            special_flag_in;
    logic [XLEN-1:0] special_in, a_mag_in, b_mag_in;
    logic [2*XLEN-1:0] a_ext_in;
    logic [XLEN-1:0] quo, rem, mul_res, div_res, final_res;

    assign op_in     = muldiv_op_e'(mdu.op_i);
    assign accept    = (state == IDLE) && mdu.start_i && !mdu.flush_i;
    assign is_div_in = mdu.op_i[2];

    always_comb begin
        a_sgn_in = 1'b0;
        b_sgn_in = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin a_sgn_in = 1'b1; b_sgn_in = 1'b1; end
            OP_MULHSU:               a_sgn_in = 1'b1;
            default:                 ;
        endcase
    end

    assign a_neg_in = a_sgn_in & mdu.a_i[XLEN-1];
    assign b_neg_in = b_sgn_in & mdu.b_i[XLEN-1];
    assign a_mag_in = neg_if(a_neg_in, mdu.a_i);
    assign b_mag_in = neg_if(b_neg_in, mdu.b_i);
    assign a_ext_in = {{XLEN{a_neg_in}}, mdu.a_i};

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;
    assign fa = $signed({a_neg_in, mdu.a_i});
    assign fb = $signed({b_neg_in, mdu.b_i});
    assign fp = fa * fb;
`endif

    // Results that need no iteration are computed at accept time.
    always_comb begin
        special_flag_in = 1'b0;
        special_in      = '0;
        if (is_div_in) begin
            if (mdu.b_i == '0) begin
                special_flag_in = 1'b1;
                special_in      = mdu.op_i[1] ? mdu.a_i : '1;
            end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                         mdu.a_i == INT_MIN && mdu.b_i == '1) begin
                special_flag_in = 1'b1;
                special_in      = mdu.op_i[1] ? '0 : mdu.a_i;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else begin
            special_flag_in = 1'b1;
            special_in      = (op_in == OP_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = special_flag_in ? DONE : (is_div_in ? DIV : MUL);
            MUL, DIV: begin
                if (mdu.flush_i)              state_nx = IDLE;
                else if (count == CNT_W'(1))  state_nx = DONE;
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            op_q          <= OP_MUL;
            rd_q          <= '0;
            rd_hold_q     <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            res_hold_q    <= '0;
            prod_q        <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q          <= op_in;
                rd_q          <= mdu.rd_i;
                count         <= CNT_W'(XLEN);
                q_neg_q       <= a_neg_in ^ b_neg_in;
                r_neg_q       <= a_neg_in;
                special_q     <= special_flag_in;
                special_res_q <= special_in;
                mcand_q       <= a_ext_in;
                mplier_q      <= mdu.b_i;
                // A negative signed multiplier contributes -a*2^XLEN from its
                // sign-extension bits; preloading that lets XLEN steps suffice.
                prod_q        <= b_neg_in ? (~(a_ext_in << XLEN) + 1'b1) : '0;
            end else if (state == MUL) begin
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count    <= count - CNT_W'(1);
            end else if (state == DIV) begin
                count <= count - CNT_W'(1);
            end else if (state == DONE && !mdu.flush_i) begin
                res_hold_q <= final_res;
                rd_hold_q  <= rd_q;
            end
        end
    end

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && is_div_in),
        .step      (state == DIV),
        .dividend  (a_mag_in),
        .divisor   (b_mag_in),
        .quotient  (quo),
        .remainder (rem)
    );

    assign mul_res   = (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
    assign div_res   = op_q[1] ? neg_if(r_neg_q, rem) : neg_if(q_neg_q, quo);
    assign final_res = special_q ? special_res_q : (op_q[2] ? div_res : mul_res);

    assign mdu.busy_o         = (state == MUL) || (state == DIV);
    assign mdu.stall_o        = accept || (mdu.busy_o && !mdu.flush_i);
    assign mdu.result_valid_o = (state == DONE) && !mdu.flush_i;
    assign mdu.result_o       = (state == DONE) ? final_res : res_hold_q;
    assign mdu.rd_o           = (state == DONE) ? rd_q : rd_hold_q;

endmodule
